// File: rtl/rvv_insn_sequencer.sv
// -----------------------------------------------------------------------------
// rvv_insn_sequencer
//
// Purpose:
//   Sits between the scalar front end and the vector core. Buffers vector
//   instructions in a small in-order queue, issues them one at a time, tracks
//   how many are issued but not yet written back, and implements a drain
//   (fence) handshake. An optional per-register busy scoreboard holds back the
//   queue head while any of its vd/vs1/vs2 registers has a write outstanding.
//
// Optional feature:
//   RVV_SCOREBOARD_EN - when defined, a NUM_VEC-bit busy vector is kept and
//                       used to detect hazards on the head instruction. When
//                       undefined, hazard is tied to 0 and ordering is left to
//                       the vector core.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous, active-low reset
//   insn_in     - instruction from the scalar front end
//   insn_valid  - insn_in is valid
//   insn_ready  - queue can accept an instruction (0 while in reset)
//   issue_insn  - queue head presented to the vector core (0 while in reset)
//   issue_valid - issue_insn is valid
//   issue_ready - vector core accepts issue_insn
//   wb_valid    - vector core retires one instruction
//   wb_vd       - destination register of the retiring instruction
//   drain_req   - pulse requesting a full drain
//   drain_ack   - one-cycle pulse when the drain completes
//   rvv_idle    - queue empty, nothing in flight, state IDLE (1 while in reset)
// -----------------------------------------------------------------------------
module rvv_insn_sequencer #(
   parameter int INSN_WIDTH   = 32,
   parameter int NUM_VEC      = 32,
   parameter int FIFO_DEPTH   = 4,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [INSN_WIDTH-1:0]      insn_in,
   input  logic                       insn_valid,
   output logic                       insn_ready,
   output logic [INSN_WIDTH-1:0]      issue_insn,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   input  logic                       wb_valid,
   input  logic [$clog2(NUM_VEC)-1:0] wb_vd,
   input  logic                       drain_req,
   output logic                       drain_ack,
   output logic                       rvv_idle
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int VR_W  = $clog2(NUM_VEC);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

   // Elaboration-time parameter sanity checks.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rvv_insn_sequencer: FIFO_DEPTH must be a power of 2 and at least 2");
   end
   if (MAX_INFLIGHT < 1) begin : g_bad_inflight
      $error("rvv_insn_sequencer: MAX_INFLIGHT must be at least 1");
   end
   if (INSN_WIDTH < 25) begin : g_bad_width
      $error("rvv_insn_sequencer: INSN_WIDTH must cover the register fields up to bit 24");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [INSN_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W:0]        r_wr_ptr;
   logic [PTR_W:0]        r_rd_ptr;
   logic [CNT_W-1:0]      r_inflight;
   state_t                r_state;
   logic                  r_drain_ack;

   // ---------------------------------------------------------------------------
   // Queue status and handshakes
   // ---------------------------------------------------------------------------
   logic                  w_empty;
   logic                  w_full;
   logic [INSN_WIDTH-1:0] w_head;
   logic                  w_push;
   logic                  w_hazard;
   logic                  w_issue_valid;
   logic                  w_issue;
   logic                  w_wb;
   logic [CNT_W-1:0]      w_inflight_nxt;

   // The extra MSB distinguishes full (index equal, wrap bit differs) from
   // empty (pointers identical).
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

   // Readiness depends only on the registered full flag, so a pop in the
   // same cycle never opens a slot for a push (no bypass when full).
   assign insn_ready = rst && !w_full;
   assign w_push     = insn_valid && insn_ready;

   // Once raised, issue_valid only falls on the handshake, a drain request
   // or reset: the head cannot change, inflight only decreases without an
   // issue, and busy bits are only set by an issue.
   assign w_issue_valid = rst && !w_empty && (r_inflight < MAX_CNT) &&
                          !w_hazard && (r_state == ST_RUN);
   assign w_issue       = w_issue_valid && issue_ready;

   // A write-back with nothing in flight is spurious and is dropped entirely,
   // which also covers the first cycle after reset.
   assign w_wb = wb_valid && (r_inflight != '0);

   // NOTE: every variable written in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_inflight_nxt = r_inflight;
      unique case ({w_issue, w_wb})
         2'b10:   w_inflight_nxt = r_inflight + CNT_W'(1);
         2'b01:   w_inflight_nxt = r_inflight - CNT_W'(1);
         default: w_inflight_nxt = r_inflight;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Optional register scoreboard
   // ---------------------------------------------------------------------------
`ifdef RVV_SCOREBOARD_EN
   logic [NUM_VEC-1:0] r_busy;
   logic [VR_W-1:0]    w_vd;
   logic [VR_W-1:0]    w_vs1;
   logic [VR_W-1:0]    w_vs2;

   assign w_vd  = w_head[7  +: VR_W];
   assign w_vs1 = w_head[15 +: VR_W];
   assign w_vs2 = w_head[20 +: VR_W];

   assign w_hazard = r_busy[w_vs1] | r_busy[w_vs2] | r_busy[w_vd];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         // The set is written after the clear, so when both hit the same
         // register in one cycle the register stays busy.
         if (w_wb) begin
            r_busy[wb_vd] <= 1'b0;
         end
         if (w_issue) begin
            r_busy[w_vd] <= 1'b1;
         end
      end
   end
`else
   logic w_unused_wb_vd;

   assign w_hazard       = 1'b0;
   assign w_unused_wb_vd = ^wb_vd;
`endif

   // ---------------------------------------------------------------------------
   // Instruction queue storage
   // ---------------------------------------------------------------------------
   // NOTE: the storage array has no reset; validity is carried entirely by the
   // pointers, so clearing the data would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= insn_in;
      end
   end

   // NOTE: sequential state is always updated with non-blocking assignments so
   // every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_inflight <= w_inflight_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   // drain_ack is registered one cycle ahead: it is set on the edge that leaves
   // the FSM in DRAIN with inflight at zero, so the pulse coincides with the
   // DRAIN -> IDLE transition cycle. A drain_req seen while already in DRAIN
   // is absorbed, giving a single acknowledge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_drain_ack <= 1'b0;
      end else begin
         r_drain_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (drain_req) begin
                  r_state     <= ST_DRAIN;
                  r_drain_ack <= (w_inflight_nxt == '0);
               end else if (w_push || !w_empty) begin
                  // Non-empty also counts: instructions accepted during a
                  // drain must still get issued afterwards.
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (drain_req) begin
                  r_state     <= ST_DRAIN;
                  r_drain_ack <= (w_inflight_nxt == '0);
               end else if (w_empty && !w_push && (w_inflight_nxt == '0)) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (r_inflight == '0) begin
                  r_state <= ST_IDLE;
               end else if (w_inflight_nxt == '0) begin
                  r_drain_ack <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (forced to their reset values while rst is low)
   // ---------------------------------------------------------------------------
   assign issue_valid = w_issue_valid;
   assign issue_insn  = (rst && !w_empty) ? w_head : '0;
   assign drain_ack   = rst && r_drain_ack;
   assign rvv_idle    = !rst ||
                        (w_empty && (r_inflight == '0) && (r_state == ST_IDLE));

endmodule

// File: tb/tb_rvv_insn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rvv_insn_sequencer
//
// Cycle-by-cycle directed vectors for rvv_insn_sequencer with default
// parameters (FIFO_DEPTH = 4, MAX_INFLIGHT = 8). Each record holds the inputs
// for one clock cycle and the outputs expected during that cycle. Inputs are
// driven just after the rising edge and outputs are sampled on the falling
// edge. Expected values were worked out by hand from the block's behaviour.
// -----------------------------------------------------------------------------
module tb_rvv_insn_sequencer;

   typedef struct {
      logic        rst;
      logic        iv;
      logic [31:0] insn;
      logic        ir;
      logic        wbv;
      logic [4:0]  wbvd;
      logic        drq;
      logic        e_rdy;
      logic        e_iv;
      logic [31:0] e_insn;
      logic        e_ack;
      logic        e_idle;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] insn_in;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] issue_insn;
   logic        issue_valid;
   logic        issue_ready;
   logic        wb_valid;
   logic [4:0]  wb_vd;
   logic        drain_req;
   logic        drain_ack;
   logic        rvv_idle;

   int n_vec = 0;
   int n_err = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   rvv_insn_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .insn_in     (insn_in),
      .insn_valid  (insn_valid),
      .insn_ready  (insn_ready),
      .issue_insn  (issue_insn),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .wb_valid    (wb_valid),
      .wb_vd       (wb_vd),
      .drain_req   (drain_req),
      .drain_ack   (drain_ack),
      .rvv_idle    (rvv_idle)
   );

   // Vector instruction with the given register fields.
   function automatic logic [31:0] mk(input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2);
      return {7'd0, vs2, vs1, 3'd0, vd, 7'h57};
   endfunction

   function automatic vec_t v(input logic rst_i, input logic iv, input logic [31:0] insn,
                              input logic ir, input logic wbv, input logic [4:0] wbvd,
                              input logic drq, input logic e_rdy, input logic e_iv,
                              input logic [31:0] e_insn, input logic e_ack,
                              input logic e_idle);
      vec_t r;
      r.rst = rst_i; r.iv = iv; r.insn = insn; r.ir = ir; r.wbv = wbv; r.wbvd = wbvd;
      r.drq = drq; r.e_rdy = e_rdy; r.e_iv = e_iv; r.e_insn = e_insn; r.e_ack = e_ack;
      r.e_idle = e_idle;
      return r;
   endfunction

   // One comparison per applied vector; issue_insn is checked whenever it is
   // defined (valid, or forced to zero by reset).
   task automatic check(input string name, input vec_t x);
      logic insn_bad;
      rst         = x.rst;
      insn_valid  = x.iv;
      insn_in     = x.insn;
      issue_ready = x.ir;
      wb_valid    = x.wbv;
      wb_vd       = x.wbvd;
      drain_req   = x.drq;
      @(negedge clk);
      n_vec++;
      insn_bad = (x.e_iv || !x.rst) && (issue_insn !== x.e_insn);
      if (insn_ready !== x.e_rdy || issue_valid !== x.e_iv || drain_ack !== x.e_ack ||
          rvv_idle !== x.e_idle || insn_bad) begin
         n_err++;
         $display("FAIL %s: got rdy=%b iv=%b insn=%h ack=%b idle=%b, want rdy=%b iv=%b insn=%h ack=%b idle=%b",
                  name, insn_ready, issue_valid, issue_insn, drain_ack, rvv_idle,
                  x.e_rdy, x.e_iv, x.e_insn, x.e_ack, x.e_idle);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] i1, i2, h1, h2;
      logic [31:0] a_i [5];
      logic [31:0] b_i [4];
      logic [31:0] c_i [5];
      logic [31:0] d_i [2];
      logic        sb;

`ifdef RVV_SCOREBOARD_EN
      sb = 1'b1;
`else
      sb = 1'b0;
`endif

      i1 = 32'h0020_80D7;   // vd=1 vs1=1 vs2=2
      i2 = 32'h0041_0157;   // vd=2 vs1=2 vs2=4
      for (int k = 0; k < 5; k++) a_i[k] = mk(5'(8 + k), 5'(16 + k), 5'(24 + k));
      for (int k = 0; k < 4; k++) b_i[k] = mk(5'(1 + k), 5'(20 + k), 5'(28 + k));
      for (int k = 0; k < 5; k++) c_i[k] = mk(5'(1 + k), 5'(10 + k), 5'(20 + k));
      for (int k = 0; k < 2; k++) d_i[k] = mk(5'(6 + k), 5'(14 + k), 5'(25 + k));
      h1 = mk(5'd1, 5'd0, 5'd0);
      h2 = mk(5'd5, 5'd1, 5'd0);

      //            rst iv insn    ir wbv vd drq | rdy iv insn    ack idle
      // Reset values
      vecs.push_back(v(0, 0, 0,      0, 0, 0, 0,   0, 0, 0,       0, 1));
      vecs.push_back(v(0, 0, 0,      0, 0, 0, 0,   0, 0, 0,       0, 1));
      // Back-to-back pushes, issue one cycle after each push, two write-backs
      vecs.push_back(v(1, 1, i1,     1, 0, 0, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 1, i2,     1, 0, 0, 0,   1, 1, i1,      0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, i2,      0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 1, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 2, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 0, 0,       0, 1));
      // Spurious write-back with nothing in flight must not underflow
      vecs.push_back(v(1, 0, 0,      1, 1, 3, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 0, 0,       0, 1));
      // Fill the queue with issue_ready low; 5th push waits for a slot
      vecs.push_back(v(1, 1, a_i[0], 0, 0, 0, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 1, a_i[1], 0, 0, 0, 0,   1, 1, a_i[0],  0, 0));
      vecs.push_back(v(1, 1, a_i[2], 0, 0, 0, 0,   1, 1, a_i[0],  0, 0));
      vecs.push_back(v(1, 1, a_i[3], 0, 0, 0, 0,   1, 1, a_i[0],  0, 0));
      vecs.push_back(v(1, 1, a_i[4], 0, 0, 0, 0,   0, 1, a_i[0],  0, 0));
      vecs.push_back(v(1, 1, a_i[4], 1, 0, 0, 0,   0, 1, a_i[0],  0, 0));
      vecs.push_back(v(1, 1, a_i[4], 0, 0, 0, 0,   1, 1, a_i[1],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   0, 1, a_i[1],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, a_i[2],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, a_i[3],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, a_i[4],  0, 0));
      // Reach MAX_INFLIGHT; the 9th waits for a write-back
      vecs.push_back(v(1, 1, b_i[0], 1, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 1, b_i[1], 1, 0, 0, 0,   1, 1, b_i[0],  0, 0));
      vecs.push_back(v(1, 1, b_i[2], 1, 0, 0, 0,   1, 1, b_i[1],  0, 0));
      vecs.push_back(v(1, 1, b_i[3], 1, 0, 0, 0,   1, 1, b_i[2],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 8, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, b_i[3],  0, 0));
      // Reset with 8 in flight; write-back right after reset is ignored
      vecs.push_back(v(0, 0, 0,      0, 0, 0, 0,   0, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      0, 1, 9, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       0, 1));
      // Drain with 3 in flight, second drain_req absorbed, push during drain
      vecs.push_back(v(1, 1, c_i[0], 1, 0, 0, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 1, c_i[1], 1, 0, 0, 0,   1, 1, c_i[0],  0, 0));
      vecs.push_back(v(1, 1, c_i[2], 1, 0, 0, 0,   1, 1, c_i[1],  0, 0));
      vecs.push_back(v(1, 1, c_i[3], 1, 0, 0, 0,   1, 1, c_i[2],  0, 0));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 1,   1, 1, c_i[3],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 1, c_i[4], 1, 0, 0, 1,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 1, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 2, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 1, 3, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       1, 0));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, c_i[3],  0, 0));
      vecs.push_back(v(1, 0, 0,      1, 0, 0, 0,   1, 1, c_i[4],  0, 0));
      // Reset with 2 queued and 2 in flight
      vecs.push_back(v(1, 1, d_i[0], 0, 0, 0, 0,   1, 0, 0,       0, 0));
      vecs.push_back(v(1, 1, d_i[1], 0, 0, 0, 0,   1, 1, d_i[0],  0, 0));
      vecs.push_back(v(0, 0, 0,      0, 0, 0, 0,   0, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      0, 1, 4, 0,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       0, 1));
      // Drain request with nothing in flight: ack on the next cycle
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 1,   1, 0, 0,       0, 1));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       1, 0));
      vecs.push_back(v(1, 0, 0,      0, 0, 0, 0,   1, 0, 0,       0, 1));

      rst = 1'b0; insn_valid = 1'b0; insn_in = '0; issue_ready = 1'b0;
      wb_valid = 1'b0; wb_vd = '0; drain_req = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         check($sformatf("vec%0d", i), vecs[i]);
      end

      // Hand-written RAW sequence: the second instruction reads vs1 = 1, which
      // the first one writes. With the scoreboard it waits for wb_vd = 1 and
      // issues the cycle after; without it, it issues straight away.
      check("raw_push1", v(1, 1, h1, 1, 0, 0, 0,   1, 0, 0,  0, 1));
      check("raw_push2", v(1, 1, h2, 1, 0, 0, 0,   1, 1, h1, 0, 0));
      if (sb) begin
         check("raw_stall", v(1, 0, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0));
         check("raw_wb",    v(1, 0, 0, 1, 1, 1, 0, 1, 0, 0,  0, 0));
         check("raw_issue", v(1, 0, 0, 1, 0, 0, 0, 1, 1, h2, 0, 0));
      end else begin
         check("raw_issue", v(1, 0, 0, 1, 0, 0, 0, 1, 1, h2, 0, 0));
         check("raw_wb",    v(1, 0, 0, 1, 1, 1, 0, 1, 0, 0,  0, 0));
         check("raw_empty", v(1, 0, 0, 1, 0, 0, 0, 1, 0, 0,  0, 0));
      end
      check("raw_wb2",  v(1, 0, 0, 1, 1, 5, 0,   1, 0, 0, 0, 0));
      check("raw_idle", v(1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rvv_insn_sequencer.md
RVV_INSN_SEQUENCER -- requirements
Module: rvv_insn_sequencer

Interface
- REQ-001: Parameter INSN_WIDTH, default 32, is the instruction width in bits.
- REQ-002: Parameter NUM_VEC, default 32, is the number of vector registers tracked by the scoreboard.
- REQ-003: Parameter FIFO_DEPTH, default 4, is the instruction queue depth; it SHALL be a power of 2, at least 2.
- REQ-004: Parameter MAX_INFLIGHT, default 8, is the maximum number of issued-but-not-written-back instructions.
- REQ-005: clk, input, 1, the single clock; all logic is on the rising edge.
- REQ-006: rst, input, 1, reset; synchronous and active-low.
- REQ-007: insn_in, input, INSN_WIDTH, instruction from the scalar front end.
- REQ-008: insn_valid, input, 1, insn_in is valid.
- REQ-009: insn_ready, output, 1, the queue can accept an instruction.
- REQ-010: issue_insn, output, INSN_WIDTH, instruction presented to the vector core.
- REQ-011: issue_valid, output, 1, issue_insn is valid.
- REQ-012: issue_ready, input, 1, the vector core accepts issue_insn.
- REQ-013: wb_valid, input, 1, the vector core retires one instruction.
- REQ-014: wb_vd, input, clog2(NUM_VEC), destination register of the retiring instruction.
- REQ-015: drain_req, input, 1, pulse requesting a full drain (fence).
- REQ-016: drain_ack, output, 1, one-cycle pulse when the drain is complete.
- REQ-017: rvv_idle, output, 1, queue empty, inflight zero and state IDLE.

Function
- REQ-018: An instruction is pushed when insn_valid && insn_ready; insn_ready = !full, with no same-cycle bypass when full.
- REQ-019: Instructions issue in FIFO order; the handshake completes on issue_valid && issue_ready.
- REQ-020: Latency: an instruction pushed in cycle N appears on issue_insn no earlier than cycle N+1.
- REQ-021: Register fields: vd = insn[11:7], vs1 = insn[19:15], vs2 = insn[24:20].
- REQ-022: issue_valid = queue non-empty && inflight < MAX_INFLIGHT && !hazard && state == RUN.
- REQ-023: While issue_valid = 1, issue_insn and issue_valid SHALL hold stable until issue_ready.
- REQ-024: The inflight counter increments on issue, decrements on wb_valid, and is unchanged when both occur in the same cycle.
- REQ-025: A wb_valid while inflight == 0 SHALL be ignored and SHALL NOT underflow the counter.
- REQ-026: FSM states are IDLE, RUN and DRAIN.
  - IDLE -> RUN on a push.
  - RUN -> IDLE when the queue is empty, inflight == 0 and no push occurs.
  - RUN or IDLE -> DRAIN on drain_req.
  - DRAIN -> IDLE when inflight == 0; drain_ack is pulsed in that same transition cycle.
- REQ-027: In DRAIN no instruction issues; pushes are still accepted while not full.
- REQ-028: If drain_req arrives in DRAIN it is absorbed, and only one drain_ack is produced.
- REQ-029: A drain_req arriving with inflight == 0 SHALL produce drain_ack on the next cycle.
- REQ-030: Queue pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
- REQ-031: When rst == 0 at a clock edge: pointers cleared, queue empty, inflight = 0, scoreboard cleared, state = IDLE.
- REQ-032: Output values during reset: insn_ready = 0, issue_valid = 0, drain_ack = 0, rvv_idle = 1, issue_insn = 0.
- REQ-033: Reset asserted mid-operation SHALL discard queued and in-flight tracking with no drain_ack; a wb_valid in the first post-reset cycle is ignored.
- REQ-034: insn_ready SHALL be 1 in the first cycle after rst returns to 1.

Configuration
- REQ-035: With macro RVV_SCOREBOARD_EN defined, the block SHALL keep a NUM_VEC-bit busy vector.
  - Each issue sets busy[vd]; each wb_valid clears busy[wb_vd].
  - If the set and the clear target the same register in one cycle, the set wins.
  - hazard = busy[vs1] | busy[vs2] | busy[vd] of the head instruction.
- REQ-036: Without RVV_SCOREBOARD_EN, hazard is constant 0, no busy vector is instantiated, and ordering relies on the vector core.

Verification
- REQ-037: Push 0x0020_80D7 and 0x0041_0157 back-to-back with issue_ready held at 1 -> both issue in order at cycles 1 and 2 after their pushes; rvv_idle = 1 after both wb_valid.
- REQ-038: Hold issue_ready = 0 and push 5 instructions with FIFO_DEPTH = 4 -> insn_ready = 0 after the 4th push; the 5th is held until one issue occurs.
- REQ-039: With RVV_SCOREBOARD_EN, issue an instruction with vd = 1, then queue one with vs1 = 1 -> the second stalls until wb_valid with wb_vd = 1, then issues the next cycle.
- REQ-040: Issue 8 instructions without writeback (MAX_INFLIGHT = 8) -> issue_valid = 0 for a 9th; one wb_valid -> the 9th issues.
- REQ-041: Assert drain_req with 3 in flight -> no further issues; drain_ack pulses exactly once, in the cycle the 3rd wb_valid brings inflight to 0.
- REQ-042: Drop rst to 0 for one cycle with 2 queued and 2 in flight -> the next cycle shows rvv_idle = 1, insn_ready = 1 and no drain_ack.
